// File: rtl/i2s_sample_transmitter_pkg.sv
// rtl/i2s_sample_transmitter_pkg.sv - shared I2S word-select encoding and frame geometry helpers
package i2s_sample_transmitter_pkg;

   localparam logic LRCLK_LEFT  = 1'b0;
   localparam logic LRCLK_RIGHT = 1'b1;

   function automatic int frame_bits(input int slot_bits);
      return 2 * slot_bits;
   endfunction

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/i2s_sample_transmitter_sample_fifo.sv
// rtl/i2s_sample_transmitter_sample_fifo.sv - sync sample FIFO between the input handshake and the frame register
module i2s_sample_transmitter_sample_fifo #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;

   assign head  = mem[rd_ptr];
   assign full  = (count == FULL_COUNT);
   assign empty = (count == '0);

   // Storage is not reset; occupancy is tracked by count alone.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/i2s_sample_transmitter.sv
// rtl/i2s_sample_transmitter.sv - mono sample to I2S stereo serialiser with bclk/lrclk generation
// Optional saturating underrun counter port enabled by I2S_UNDERRUN_COUNT_EN.
module i2s_sample_transmitter
   import i2s_sample_transmitter_pkg::*;
#(
   parameter int DATA_BITS  = 12,
   parameter int SLOT_BITS  = 32,
   parameter int BCLK_DIV   = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 main_clk,
   input  logic                 rst_n,
   input  logic [DATA_BITS-1:0] sample_data,
   input  logic                 sample_valid,
   output logic                 sample_ready,
   output logic                 i2s_bclk,
   output logic                 i2s_lrclk,
   output logic                 i2s_sdata,
   output logic                 underrun
`ifdef I2S_UNDERRUN_COUNT_EN
   ,
   output logic [15:0]          underrun_cnt
`endif
);
   localparam int FRAME_BITS = frame_bits(SLOT_BITS);
   localparam int BC_W       = idx_width(FRAME_BITS);
   localparam int SLOT_W     = idx_width(SLOT_BITS);
   localparam int DIV_W      = idx_width(BCLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

   logic [DIV_W-1:0]     div_cnt;
   logic [BC_W-1:0]      bc;
   logic [BC_W-1:0]      bc_next;
   logic [DATA_BITS-1:0] frame_reg;
   logic [SLOT_BITS-1:0] slot_word;
   logic [DATA_BITS-1:0] fifo_head;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 tick;
   logic                 fall;
   logic                 frame_start;
   logic                 push;
   logic                 pop;

   assign tick        = (div_cnt == DIV_LAST);
   assign fall        = tick & i2s_bclk;
   assign bc_next     = bc + 1'b1;
   assign frame_start = fall & (bc_next == '0);
   assign push        = sample_valid & ~fifo_full;
   assign pop         = frame_start & ~fifo_empty;
   assign sample_ready = ~fifo_full;

   // Left-justified slot; the same word feeds both channels.
   assign slot_word = {frame_reg, {(SLOT_BITS - DATA_BITS){1'b0}}};

   i2s_sample_transmitter_sample_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_sample_fifo (
      .clk       (main_clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (sample_data),
      .pop       (pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge main_clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt   <= '0;
         i2s_bclk  <= 1'b0;
         bc        <= '0;
         i2s_lrclk <= LRCLK_LEFT;
         i2s_sdata <= 1'b0;
         frame_reg <= '0;
         underrun  <= 1'b0;
      end else begin
         underrun <= 1'b0;
         div_cnt  <= tick ? '0 : div_cnt + 1'b1;
         if (tick) begin
            i2s_bclk <= ~i2s_bclk;
         end
         // The old bc selects the bit, giving the one-bclk I2S delay; at frame start
         // this still reads the previous frame_reg for the trailing right LSB.
         if (fall) begin
            bc        <= bc_next;
            i2s_lrclk <= bc_next[BC_W-1] ? LRCLK_RIGHT : LRCLK_LEFT;
            i2s_sdata <= slot_word[~bc[SLOT_W-1:0]];
         end
         if (frame_start) begin
            frame_reg <= fifo_empty ? '0 : fifo_head;
            underrun  <= fifo_empty;
         end
      end
   end

`ifdef I2S_UNDERRUN_COUNT_EN
   always_ff @(posedge main_clk or negedge rst_n) begin
      if (!rst_n) begin
         underrun_cnt <= '0;
      end else if (underrun && (underrun_cnt != 16'hFFFF)) begin
         underrun_cnt <= underrun_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_i2s_sample_transmitter.sv
// tb/tb_i2s_sample_transmitter.sv - scoreboard bench for i2s_sample_transmitter (I2S_UNDERRUN_COUNT_EN aware)
module tb_i2s_sample_transmitter;
   localparam int DEPTH      = 4;
   localparam int FRAME_CLKS = 256;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [11:0] sample_data = '0;
   logic        sample_valid = 1'b0;
   logic        sample_ready;
   logic        i2s_bclk;
   logic        i2s_lrclk;
   logic        i2s_sdata;
   logic        underrun;
`ifdef I2S_UNDERRUN_COUNT_EN
   logic [15:0] underrun_cnt;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   logic [11:0] ref_q[$];
   logic [11:0] exp_frames[$];
   logic [11:0] dec_log[$];
   logic        exp_underrun;
   logic        prev_bclk;
   logic        prev_lr;
   logic        first_rise;
   int          last_rise;
   logic [31:0] shift;
   logic [31:0] left_word;

   i2s_sample_transmitter #(
      .DATA_BITS  (12),
      .SLOT_BITS  (32),
      .BCLK_DIV   (2),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .main_clk     (clk),
      .rst_n        (rst_n),
      .sample_data  (sample_data),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .i2s_bclk     (i2s_bclk),
      .i2s_lrclk    (i2s_lrclk),
      .i2s_sdata    (i2s_sdata),
      .underrun     (underrun)
`ifdef I2S_UNDERRUN_COUNT_EN
      ,
      .underrun_cnt (underrun_cnt)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model and I2S receiver, evaluated between clock edges.
   always @(negedge clk) begin
      logic        ready_model;
      logic [11:0] e;
      if (!rst_n) begin
         ref_q.delete();
         exp_frames.delete();
         exp_frames.push_back(12'h000);
         exp_underrun = 1'b0;
         prev_bclk    = 1'b0;
         prev_lr      = 1'b0;
         first_rise   = 1'b1;
         last_rise    = 0;
         shift        = '0;
         left_word    = '0;
      end else begin
         check("underrun", 32'(underrun), 32'(exp_underrun));
         ready_model = (ref_q.size() < DEPTH);
         check("sample_ready", 32'(sample_ready), 32'(ready_model));

         if (i2s_bclk && !prev_bclk) begin
            if (first_rise) check("first_bclk_rise_cycle", 32'(cyc), 32'd2);
            else            check("bclk_period", 32'(cyc - last_rise), 32'd4);
            first_rise = 1'b0;
            last_rise  = cyc;
            shift = {shift[30:0], i2s_sdata};
            if (i2s_lrclk != prev_lr) begin
               if (!prev_lr) begin
                  left_word = shift;
               end else begin
                  if (exp_frames.size() == 0) begin
                     check("frame_expected", 32'd0, 32'd1);
                  end else begin
                     e = exp_frames.pop_front();
                     check("left_slot", left_word, {e, 20'h0});
                     check("right_slot", shift, {e, 20'h0});
                  end
                  dec_log.push_back(shift[31:20]);
               end
            end
            prev_lr = i2s_lrclk;
         end
         prev_bclk = i2s_bclk;

         exp_underrun = 1'b0;
         if ((cyc + 1) % FRAME_CLKS == 0) begin
            if (ref_q.size() == 0) begin
               exp_frames.push_back(12'h000);
               exp_underrun = 1'b1;
            end else begin
               exp_frames.push_back(ref_q.pop_front());
            end
         end
         if (sample_valid && ready_model) ref_q.push_back(sample_data);
      end
   end

   task automatic wait_cyc(input int target);
      while (cyc < target) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic push_one(input logic [11:0] d, output int acc);
      int waited;
      waited = 0;
      acc = -1;
      sample_data  = d;
      sample_valid = 1'b1;
      while (acc < 0) begin
         @(negedge clk);
         if (sample_ready) begin
            @(posedge clk);
            #2;
            acc = cyc;
         end else begin
            waited++;
            if (waited > 1000) begin
               check("push_timeout", 32'd1, 32'd0);
               acc = 0;
            end
         end
      end
      sample_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int acc;
      int accs[5];
      logic [11:0] full_vals[5] = '{12'h9AB, 12'h1F0, 12'hFFF, 12'h001, 12'h555};
      logic [11:0] pre_tbl[14] = '{12'h000, 12'h801, 12'h7FF, 12'h000, 12'h000, 12'h000,
                                   12'h000, 12'h000, 12'h123, 12'h9AB, 12'h1F0, 12'hFFF,
                                   12'h001, 12'h555};

      repeat (3) @(posedge clk);
      #2;
      check("rst_bclk", 32'(i2s_bclk), 32'd0);
      check("rst_lrclk", 32'(i2s_lrclk), 32'd0);
      check("rst_sdata", 32'(i2s_sdata), 32'd0);
      check("rst_underrun", 32'(underrun), 32'd0);
      check("rst_ready", 32'(sample_ready), 32'd1);
`ifdef I2S_UNDERRUN_COUNT_EN
      check("rst_underrun_cnt", 32'(underrun_cnt), 32'd0);
`endif
      rst_n = 1'b1;

      push_one(12'h801, acc);
      check("first_accept_cycle", 32'(acc), 32'd1);

      wait_cyc(300);
      push_one(12'h7FF, acc);
      push_one(12'h000, acc);

      wait_cyc(1600);
`ifdef I2S_UNDERRUN_COUNT_EN
      check("underrun_cnt_after_3", 32'(underrun_cnt), 32'd3);
`endif

      // Push lands on the frame-start edge at cycle 1792 with the FIFO empty.
      wait_cyc(1791);
      sample_data  = 12'h123;
      sample_valid = 1'b1;
      @(posedge clk);
      #2;
      sample_valid = 1'b0;
      @(negedge clk);
      check("push_on_frame_start_underrun", 32'(underrun), 32'd1);

      wait_cyc(2050);
      for (int i = 0; i < 5; i++) begin
         push_one(full_vals[i], accs[i]);
      end
      check("fourth_accept_cycle", 32'(accs[3]), 32'd2054);
      check("fifth_accept_cycle", 32'(accs[4]), 32'd2305);

      wait_cyc(3600);
      check("pre_reset_frame_count", 32'(dec_log.size()), 32'd14);
      for (int i = 0; i < 14 && i < dec_log.size(); i++) begin
         check($sformatf("frame_%0d", i), 32'(dec_log[i]), 32'(pre_tbl[i]));
      end
      if (dec_log.size() > 2) begin
         check("signed_2047", 32'($signed(dec_log[2])), 32'd2047);
      end

      // Reset with bc=20 and bclk high.
      wait_cyc(3666);
`ifdef I2S_UNDERRUN_COUNT_EN
      check("underrun_cnt_pre_reset", 32'(underrun_cnt), 32'd5);
`endif
      check("pre_reset_bclk_high", 32'(i2s_bclk), 32'd1);
      rst_n = 1'b0;
      #1;
      check("midrst_bclk", 32'(i2s_bclk), 32'd0);
      check("midrst_lrclk", 32'(i2s_lrclk), 32'd0);
      check("midrst_sdata", 32'(i2s_sdata), 32'd0);
      check("midrst_underrun", 32'(underrun), 32'd0);
      check("midrst_ready", 32'(sample_ready), 32'd1);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;

      push_one(12'hC5A, acc);
      wait_cyc(800);
      check("total_frame_count", 32'(dec_log.size()), 32'd17);
      if (dec_log.size() == 17) begin
         check("post_reset_frame0", 32'(dec_log[14]), 32'h000);
         check("post_reset_frame1", 32'(dec_log[15]), 32'hC5A);
         check("post_reset_frame2", 32'(dec_log[16]), 32'h000);
      end
`ifdef I2S_UNDERRUN_COUNT_EN
      check("underrun_cnt_final", 32'(underrun_cnt), 32'd2);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
